// File: rtl/logistic_score_engine_if.sv
// Register-file bus between the score engine (master) and the pixel/weight register file (slave).
// Latency: reads return data on rf_data_out one cycle after the rf_en_read strobe.
// Backpressure: none; the master owns the bus outright while it drives it.
//
// Signals:
//   rf_address   register-file address
//   rf_en_read   read strobe
//   rf_en_write  write strobe
//   rf_data_in   write data towards the register file
//   rf_data_out  read data from the register file
interface logistic_score_engine_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_DEPTH = 12
);
  logic [ADDR_DEPTH-1:0] rf_address;
  logic                  rf_en_read;
  logic                  rf_en_write;
  logic [DATA_WIDTH-1:0] rf_data_in;
  logic [DATA_WIDTH-1:0] rf_data_out;

  modport master (
    output rf_address,
    output rf_en_read,
    output rf_en_write,
    output rf_data_in,
    input  rf_data_out
  );

  modport slave (
    input  rf_address,
    input  rf_en_read,
    input  rf_en_write,
    input  rf_data_in,
    output rf_data_out
  );
endinterface

// File: rtl/logistic_score_engine.sv
// Dot-product scorer: bias + sum(pixel x weight) over N_PIXELS RGB words, saturated, written back.
// Latency: start sampled at edge k -> busy from cycle k+1, done pulse in cycle k+2N+5.
// Backpressure: none; the engine owns the register-file bus while busy=1 and ignores start until idle.
//
// Ports:
//   clock, rst    rising-edge clock, asynchronous active-high reset
//   control_reg   start bit (register 0, bit 0)
//   rf            register-file bus (master side)
//   busy          engine owns the bus (external mux select)
//   done          one-cycle pulse after result written and start bit cleared
//   score/is_cat  last saturated score and decision (accumulator >= 0), held until next run
module logistic_score_engine #(
  parameter int DATA_WIDTH  = 24,
  parameter int ADDR_DEPTH  = 12,
  parameter int N_PIXELS    = 1024,
  parameter int BIAS_ADDR   = 1,
  parameter int RESULT_ADDR = 2,
  parameter int PIX_BASE    = 16,
  parameter int WGT_BASE    = 2048,
  parameter int ACC_WIDTH   = 32
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     control_reg,
  logistic_score_engine_if.master  rf,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    score,
  output logic                     is_cat
);

  localparam int CNT_WIDTH = $clog2(N_PIXELS) + 1;
  localparam logic [CNT_WIDTH-1:0]  LAST_IDX = CNT_WIDTH'(N_PIXELS - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [ADDR_DEPTH-1:0] BIAS_A   = ADDR_DEPTH'(BIAS_ADDR);
  localparam logic [ADDR_DEPTH-1:0] RESULT_A = ADDR_DEPTH'(RESULT_ADDR);
  localparam logic [ADDR_DEPTH-1:0] PIX_A    = ADDR_DEPTH'(PIX_BASE);
  localparam logic [ADDR_DEPTH-1:0] CTRL_A   = '0;

  // Saturation bounds of a signed DATA_WIDTH result, held at accumulator width.
  localparam longint SAT_MAX_L = (longint'(1) << (DATA_WIDTH - 1)) - 1;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(SAT_MAX_L);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-SAT_MAX_L - 1);

  typedef enum logic [2:0] {
    IDLE, RD_BIAS, RD_PIX, RD_WGT, LAST_ACC, WR_RESULT, CLR_CTRL, DONE
  } state_t;

  state_t                       state;
  logic [CNT_WIDTH-1:0]         idx;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic [DATA_WIDTH-1:0]        pix_q;

  logic signed [8:0]            pix_lane;
  logic signed [7:0]            wgt_lane;
  logic signed [16:0]           prod;
  logic signed [ACC_WIDTH-1:0]  lane_sum;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic signed [ACC_WIDTH-1:0]  bias_ext;

  function automatic logic [DATA_WIDTH-1:0] sat_score(input logic signed [ACC_WIDTH-1:0] a);
    if (a > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (a < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return a[DATA_WIDTH-1:0];
  endfunction

  // Pixel lanes are unsigned, weight lanes signed; each product fits in 17 signed bits.
  // rf_data_out carries the weight of the previous element whenever acc_sum is consumed.
  always_comb begin
    pix_lane = '0;
    wgt_lane = '0;
    prod     = '0;
    lane_sum = '0;
    for (int l = 0; l < 3; l++) begin
      pix_lane = $signed({1'b0, pix_q[8*l +: 8]});
      wgt_lane = $signed(rf.rf_data_out[8*l +: 8]);
      prod     = 17'(pix_lane) * 17'(wgt_lane);
      lane_sum = lane_sum + ACC_WIDTH'(prod);
    end
    acc_sum  = acc + lane_sum;
    bias_ext = {{(ACC_WIDTH-DATA_WIDTH){rf.rf_data_out[DATA_WIDTH-1]}}, rf.rf_data_out};
  end

  // Bus outputs are set on the edge entering the state that owns them, so every
  // strobe/address is registered and lines up with the state it belongs to.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      acc            <= '0;
      pix_q          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      score          <= '0;
      is_cat         <= 1'b0;
      rf.rf_address  <= '0;
      rf.rf_en_read  <= 1'b0;
      rf.rf_en_write <= 1'b0;
      rf.rf_data_in  <= '0;
    end else begin
      rf.rf_en_read  <= 1'b0;
      rf.rf_en_write <= 1'b0;
      done           <= 1'b0;
      case (state)
        IDLE: begin
          if (control_reg) begin
            state         <= RD_BIAS;
            busy          <= 1'b1;
            rf.rf_en_read <= 1'b1;
            rf.rf_address <= BIAS_A;
          end
        end
        RD_BIAS: begin
          state         <= RD_PIX;
          idx           <= '0;
          rf.rf_en_read <= 1'b1;
          rf.rf_address <= PIX_A;
        end
        RD_PIX: begin
          // First visit: bias is on the data bus. Later: previous weight is on it.
          acc           <= (idx == '0) ? bias_ext : acc_sum;
          state         <= RD_WGT;
          rf.rf_en_read <= 1'b1;
          rf.rf_address <= ADDR_DEPTH'(WGT_BASE + int'(idx));
        end
        RD_WGT: begin
          pix_q <= rf.rf_data_out;
          idx   <= idx + CNT_ONE;
          if (idx == LAST_IDX) begin
            state <= LAST_ACC;
          end else begin
            state         <= RD_PIX;
            rf.rf_en_read <= 1'b1;
            rf.rf_address <= ADDR_DEPTH'(PIX_BASE + int'(idx) + 1);
          end
        end
        LAST_ACC: begin
          acc            <= acc_sum;
          state          <= WR_RESULT;
          rf.rf_en_write <= 1'b1;
          rf.rf_address  <= RESULT_A;
          rf.rf_data_in  <= sat_score(acc_sum);
        end
        WR_RESULT: begin
          score          <= sat_score(acc);
          is_cat         <= ~acc[ACC_WIDTH-1];
          state          <= CLR_CTRL;
          rf.rf_en_write <= 1'b1;
          rf.rf_address  <= CTRL_A;
          rf.rf_data_in  <= '0;
        end
        CLR_CTRL: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          // Start bit was cleared by the CLR_CTRL write, so IDLE will not retrigger.
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logistic_score_engine.sv
// Bench for logistic_score_engine with a behavioural register file and a queue-based scoreboard.
// Latency: expects done 2N+4 cycles after busy rises.
// Backpressure: none; the register-file model answers every read one cycle later.
module tb_logistic_score_engine;
  localparam int DW = 24;
  localparam int AW = 12;
  localparam int N  = 4;
  localparam int BIAS_ADDR   = 1;
  localparam int RESULT_ADDR = 2;
  localparam int PIX_BASE    = 16;
  localparam int WGT_BASE    = 2048;

  logic          clock = 1'b0;
  logic          rst   = 1'b0;
  logic          control_reg;
  logic          busy, done, is_cat;
  logic [DW-1:0] score;

  always #5 clock = ~clock;

  logistic_score_engine_if #(.DATA_WIDTH(DW), .ADDR_DEPTH(AW)) rf ();

  logistic_score_engine #(
    .DATA_WIDTH(DW), .ADDR_DEPTH(AW), .N_PIXELS(N), .BIAS_ADDR(BIAS_ADDR),
    .RESULT_ADDR(RESULT_ADDR), .PIX_BASE(PIX_BASE), .WGT_BASE(WGT_BASE), .ACC_WIDTH(32)
  ) dut (
    .clock(clock), .rst(rst), .control_reg(control_reg), .rf(rf),
    .busy(busy), .done(done), .score(score), .is_cat(is_cat)
  );

  // Register file model: engine port plus a bench write port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          tb_wr_en = 1'b0;
  logic [AW-1:0] tb_wr_addr = '0;
  logic [DW-1:0] tb_wr_dat = '0;

  always @(posedge clock) begin
    if (rf.rf_en_read)  rf.rf_data_out <= mem[rf.rf_address];
    if (rf.rf_en_write) mem[rf.rf_address] <= rf.rf_data_in;
    if (tb_wr_en)       mem[tb_wr_addr] <= tb_wr_dat;
  end
  assign control_reg = mem[0][0];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] score;
    logic          is_cat;
    int            exp_start;
    int            exp_done;
  } exp_t;
  exp_t sb[$];

  int vecs = 0;
  int miscompares = 0;

  logic [DW-1:0] pix_a [N];
  logic [DW-1:0] wgt_a [N];
  logic [DW-1:0] bias_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer dot product with the stated lane rules, then clamp.
  function automatic exp_t model();
    exp_t e;
    longint acc;
    logic [7:0] pb, wb;
    acc = longint'($signed(bias_v));
    for (int i = 0; i < N; i++) begin
      for (int l = 0; l < 3; l++) begin
        pb = pix_a[i][8*l +: 8];
        wb = wgt_a[i][8*l +: 8];
        acc += longint'(pb) * longint'($signed(wb));
      end
    end
    if (acc > 8388607)       e.score = 24'h7FFFFF;
    else if (acc < -8388608) e.score = 24'h800000;
    else                     e.score = acc[23:0];
    e.is_cat    = (acc >= 0);
    e.exp_start = 0;
    e.exp_done  = 0;
    return e;
  endfunction

  function automatic logic [31:0] exp_rd_addr(input int j);
    if (j == 0)          return BIAS_ADDR;
    else if (j % 2 == 1) return PIX_BASE + (j - 1) / 2;
    else                 return WGT_BASE + (j - 2) / 2;
  endfunction

  task automatic push_exp(input int busy_cyc);
    exp_t e;
    e = model();
    e.exp_start = busy_cyc;
    e.exp_done  = busy_cyc + 2 * N + 4;
    sb.push_back(e);
  endtask

  // Called and returns at a falling edge.
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tb_wr_en = 1'b1; tb_wr_addr = a; tb_wr_dat = d;
    @(negedge clock);
    tb_wr_en = 1'b0;
  endtask

  // Start bit lands after the next rising edge; the engine samples it one edge later.
  task automatic launch();
    wr(AW'(BIAS_ADDR), bias_v);
    for (int i = 0; i < N; i++) begin
      wr(AW'(PIX_BASE + i), pix_a[i]);
      wr(AW'(WGT_BASE + i), wgt_a[i]);
    end
    push_exp(cyc + 2);
    wr('0, 24'h000001);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 200 && (sb.size() > 0 || busy); t++) @(negedge clock);
    check("run_completes", sb.size(), 0);
    if (sb.size() > 0) sb.delete();
    repeat (3) @(negedge clock);
  endtask

  task automatic set_uniform(input logic [DW-1:0] b, input logic [DW-1:0] p, input logic [DW-1:0] w);
    bias_v = b;
    for (int i = 0; i < N; i++) begin
      pix_a[i] = p;
      wgt_a[i] = w;
    end
  endtask

  // Monitor: samples mid-cycle, checks bus legality every cycle and pops on done.
  int mon_prev_busy = 0;
  int mon_rd_n = 0;
  int mon_wr_n = 0;
  int mon_last_done = -10;

  initial begin
    forever begin
      @(posedge clock);
      #3;
      if (rst) begin
        check("rst_strobes", {30'd0, rf.rf_en_read, rf.rf_en_write}, 0);
        check("rst_busy_done", {30'd0, busy, done}, 0);
        mon_prev_busy = 0;
      end else begin
        check("bus_conflict", rf.rf_en_read & rf.rf_en_write, 0);
        check("idle_strobe", (rf.rf_en_read | rf.rf_en_write) & ~busy, 0);
        if (busy && mon_prev_busy == 0) begin
          check("run_expected", sb.size() > 0, 1);
          if (sb.size() > 0) check("busy_start", cyc, sb[0].exp_start);
          mon_rd_n = 0;
          mon_wr_n = 0;
        end
        if (!busy && mon_prev_busy == 1) check("busy_end", cyc, mon_last_done + 1);
        if (rf.rf_en_read && busy) begin
          check("rd_addr", 32'(rf.rf_address), exp_rd_addr(mon_rd_n));
          mon_rd_n++;
        end
        if (rf.rf_en_write && busy && sb.size() > 0) begin
          check("wr_addr", 32'(rf.rf_address), (mon_wr_n == 0) ? RESULT_ADDR : 0);
          check("wr_data", 32'(rf.rf_data_in), (mon_wr_n == 0) ? 32'(sb[0].score) : 0);
          mon_wr_n++;
        end
        if (done) begin
          check("done_expected", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            check("done_cycle", cyc, sb[0].exp_done);
            check("score", 32'(score), 32'(sb[0].score));
            check("is_cat", 32'(is_cat), 32'(sb[0].is_cat));
            check("busy_at_done", 32'(busy), 1);
            check("read_count", mon_rd_n, 2 * N + 1);
            check("write_count", mon_wr_n, 2);
            check("reg_result", 32'(mem[RESULT_ADDR]), 32'(sb[0].score));
            check("reg_ctrl", 32'(mem[0]), 0);
            void'(sb.pop_front());
          end
          mon_last_done = cyc;
        end
        mon_prev_busy = busy ? 1 : 0;
      end
    end
  end

  initial begin
    // Mid-cycle reset: outputs must clear immediately.
    #1 rst = 1'b1;
    #1;
    check("reset_outputs", {busy, done, is_cat, score}, 0);
    check("reset_bus", {rf.rf_en_read, rf.rf_en_write, rf.rf_address}, 0);
    @(negedge clock);
    wr('0, '0);
    @(negedge clock);
    rst = 1'b0;
    repeat (2) @(negedge clock);

    // Uniform pattern with unit weights.
    set_uniform(24'h000000, 24'h010203, 24'h010101);
    launch();
    wait_idle();
    check("t2_score", score, 24'h000018);
    check("t2_cat", is_cat, 1);

    // Max pixels against -1 weights.
    set_uniform(24'h000000, 24'hFFFFFF, 24'hFFFFFF);
    launch();
    wait_idle();
    check("t3_score", score, 24'hFFF40C);
    check("t3_cat", is_cat, 0);

    // Positive saturation.
    set_uniform(24'h7FFFFF, 24'hFFFFFF, 24'h7F7F7F);
    launch();
    wait_idle();
    check("t4_score", score, 24'h7FFFFF);
    check("t4_cat", is_cat, 1);

    // Negative saturation.
    set_uniform(24'h800000, 24'hFFFFFF, 24'h808080);
    launch();
    wait_idle();
    check("neg_sat_score", score, 24'h800000);
    check("neg_sat_cat", is_cat, 0);

    // Reset during RD_WGT(2) with start still set: run restarts after release.
    set_uniform(24'h000000, 24'h010203, 24'h010101);
    launch();
    repeat (7) @(negedge clock);
    rst = 1'b1;
    #1;
    check("abort_outputs", {busy, done, is_cat, score}, 0);
    check("abort_bus", {rf.rf_en_read, rf.rf_en_write}, 0);
    sb.delete();
    repeat (3) @(negedge clock);
    push_exp(cyc + 1);
    rst = 1'b0;
    wait_idle();
    check("t5_score", score, 24'h000018);

    // Start bit toggled during a run: must not cause a second run.
    set_uniform(24'h000123, 24'h102030, 24'hF00F7F);
    launch();
    repeat (2) @(negedge clock);
    wr('0, 24'h000000);
    wr('0, 24'h000001);
    wr('0, 24'h000000);
    wr('0, 24'h000001);
    wait_idle();
    repeat (10) @(negedge clock);
    check("no_retrigger_busy", busy, 0);

    // Random images.
    for (int r = 0; r < 8; r++) begin
      bias_v = DW'($urandom);
      for (int i = 0; i < N; i++) begin
        pix_a[i] = DW'($urandom);
        wgt_a[i] = DW'($urandom);
      end
      launch();
      wait_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
